// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter
//   SPI slave serial engine. Oversamples SS_n/SCLK/MOSI on PCLK, deserialises
//   MOSI into rx words and serialises a buffered tx word onto MISO. Supports
//   CPOL/CPHA modes 0..3 and MSB- or LSB-first order.
//
// Ports
//   PCLK, PRESET              clock, async active-high reset
//   spe_i                     slave enable (0 forces IDLE)
//   cpol_i, cpha_i, lsbfe_i   frame format, latched on IDLE->SHIFT
//   ss_n_i, sclk_i, mosi_i    asynchronous pins from the master
//   miso_o, miso_oe_o         serial data out and its output enable
//   tx_data_i, tx_load_i      transmit holding register write port
//   tx_ready_o                holding register empty
//   rx_data_o, rx_valid_o     last complete rx word and its update pulse
//   tx_underrun_o             pulse: shift register loaded from an empty buffer
//   busy_o                    frame in progress (SHIFT)
module spi_slave_shifter #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              spe_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic              ss_n_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);

    localparam int              CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_q, state_d;

    // ---------------- input conditioning ----------------
    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   sclk_d;
    logic                   ss_s, sclk_s, mosi_s;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_d    <= sclk_s;
        end
    end

    logic sclk_rise, sclk_fall;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // ---------------- FSM ----------------
    logic enter, leave;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        leave   = 1'b0;
        case (state_q)
            IDLE:  if (!ss_s && spe_i) begin
                       state_d = SHIFT;
                       enter   = 1'b1;
                   end
            SHIFT: if (ss_s || !spe_i) begin
                       state_d = IDLE;
                       leave   = 1'b1;
                   end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q == SHIFT);
    assign miso_oe_o = (state_q == SHIFT);

    // ---------------- datapath ----------------
    logic              mode_cpol, mode_cpha, mode_lsb;
    logic [CNT_W-1:0]  bit_cnt;
    logic              skip_first, reload_pending;
    logic [DATA_W-1:0] tx_shift, rx_shift, rx_next, tx_adv, tx_hold;
    logic              active, sample_stb, shift_stb, frame_done, buf_load;

    // Strobes are ignored in the cycle the FSM is leaving SHIFT so that an
    // abort never completes a word or consumes the holding register.
    assign active     = (state_q == SHIFT) && !leave;
    assign sample_stb = active && ((mode_cpol == mode_cpha) ? sclk_rise : sclk_fall);
    assign shift_stb  = active && ((mode_cpol == mode_cpha) ? sclk_fall : sclk_rise);
    assign frame_done = sample_stb && (bit_cnt == LAST);
    assign buf_load   = enter || (shift_stb && !skip_first && reload_pending);

    assign rx_next = mode_lsb ? {mosi_s, rx_shift[DATA_W-1:1]}
                              : {rx_shift[DATA_W-2:0], mosi_s};
    assign tx_adv  = mode_lsb ? {1'b1, tx_shift[DATA_W-1:1]}
                              : {tx_shift[DATA_W-2:0], 1'b1};

    assign miso_o = mode_lsb ? tx_shift[0] : tx_shift[DATA_W-1];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            mode_cpol      <= 1'b0;
            mode_cpha      <= 1'b0;
            mode_lsb       <= 1'b0;
            bit_cnt        <= '0;
            skip_first     <= 1'b0;
            reload_pending <= 1'b0;
            tx_shift       <= '1;
            rx_shift       <= '0;
            rx_data_o      <= '0;
            rx_valid_o     <= 1'b0;
            tx_underrun_o  <= 1'b0;
        end else begin
            rx_valid_o    <= frame_done;
            tx_underrun_o <= buf_load && tx_ready_o;

            if (enter) begin
                mode_cpol      <= cpol_i;
                mode_cpha      <= cpha_i;
                mode_lsb       <= lsbfe_i;
                bit_cnt        <= '0;
                skip_first     <= cpha_i;   // CPHA=1: first shift edge only opens the bit
                reload_pending <= 1'b0;
                rx_shift       <= '0;
            end else if (leave) begin
                bit_cnt        <= '0;
                skip_first     <= 1'b0;
                reload_pending <= 1'b0;
            end else begin
                if (sample_stb) begin
                    rx_shift <= rx_next;
                    if (frame_done) begin
                        bit_cnt        <= '0;
                        reload_pending <= 1'b1;
                        rx_data_o      <= rx_next;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                if (shift_stb) begin
                    if (skip_first)          skip_first     <= 1'b0;
                    else if (reload_pending) reload_pending <= 1'b0;
                    else                     tx_shift       <= tx_adv;
                end
            end

            // An empty buffer sends all-ones rather than stale data.
            if (buf_load) tx_shift <= tx_ready_o ? '1 : tx_hold;
        end
    end

    // Holding register. A write in the same cycle as a buffer load lands
    // after the shift register has taken the old content.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_hold    <= '0;
            tx_ready_o <= 1'b1;
        end else if (tx_load_i && tx_ready_o) begin
            tx_hold    <= tx_data_i;
            tx_ready_o <= 1'b0;
        end else if (buf_load) begin
            tx_ready_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_slave_shifter.sv
module tb_spi_slave_shifter;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       spe, cpol, cpha, lsbfe, ss_n, sclk, mosi;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic       tx_load;
    logic [7:0] tx_data, rx_data;

    localparam int HALF = 8;   // PCLKs per SCLK phase

    spi_slave_shifter #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .spe_i(spe),
        .cpol_i(cpol), .cpha_i(cpha), .lsbfe_i(lsbfe),
        .ss_n_i(ss_n), .sclk_i(sclk), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe),
        .tx_data_i(tx_data), .tx_load_i(tx_load), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .tx_underrun_o(tx_underrun), .busy_o(busy)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0, n_err = 0;
    int rxv_cnt = 0, und_cnt = 0;

    // reference model of the holding register
    bit         hold_full = 1'b0;
    logic [7:0] hold_w    = 8'h00;

    always @(negedge PCLK) begin
        if (rx_valid === 1'b1)    rxv_cnt++;
        if (tx_underrun === 1'b1) und_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic half_wait();
        repeat (HALF) @(negedge PCLK);
    endtask

    task automatic load_tx(input logic [7:0] w);
        check("tx_ready_before_load", tx_ready, !hold_full);
        tx_data = w; tx_load = 1'b1;
        @(negedge PCLK);
        tx_load = 1'b0;
        if (!hold_full) begin hold_full = 1'b1; hold_w = w; end
        check("tx_ready_after_load", tx_ready, 0);
    endtask

    // model of a buffer->shift-register load event; returns the word the slave will send
    function automatic logic [7:0] take_word(inout int exp_und);
        logic [7:0] w;
        if (hold_full) w = hold_w;
        else begin w = 8'hFF; exp_und++; end
        hold_full = 1'b0;
        return w;
    endfunction

    task automatic ss_fall(input bit p, input bit h, input bit l);
        cpol = p; cpha = h; lsbfe = l; sclk = p;
        repeat (HALF) @(negedge PCLK);
        ss_n = 1'b0;
    endtask

    task automatic ss_rise();
        ss_n = 1'b1;
        repeat (HALF + 2) @(negedge PCLK);
    endtask

    // Master side of one frame: drives MOSI, toggles SCLK, captures MISO.
    task automatic xfer(input bit h, input bit l, input logic [7:0] mo, input int nbits,
                        input bit chk_entry, input int load_at, input logic [7:0] load_w,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = l ? i : 7 - i;
            if (i == load_at) load_tx(load_w);
            if (!h) begin
                mosi = mo[b];
                half_wait();
                if (i == 0 && chk_entry) begin
                    check("busy_in_frame", busy, 1);
                    check("miso_oe_in_frame", miso_oe, 1);
                    check("tx_ready_after_ss_fall", tx_ready, !hold_full);
                end
                sclk = ~sclk; mi[b] = miso;      // leading edge: master samples
                half_wait();
                sclk = ~sclk;                    // trailing edge: both shift
            end else begin
                half_wait();
                if (i == 0 && chk_entry) begin
                    check("busy_in_frame", busy, 1);
                    check("miso_oe_in_frame", miso_oe, 1);
                    check("tx_ready_after_ss_fall", tx_ready, !hold_full);
                end
                sclk = ~sclk; mosi = mo[b];      // leading edge: both shift
                half_wait();
                sclk = ~sclk; mi[b] = miso;      // trailing edge: master samples
            end
        end
        half_wait();
    endtask

    task automatic run_frame(input bit p, input bit h, input bit l, input logic [7:0] mo);
        logic [7:0] mi, exp_tx;
        int exp_und = 0, rx0 = rxv_cnt, u0 = und_cnt;
        exp_tx = take_word(exp_und);
        ss_fall(p, h, l);
        xfer(h, l, mo, 8, 1'b1, -1, 8'h00, mi);
        // CPHA=0 ends on a shift edge, which already pulls the next word
        if (!h) void'(take_word(exp_und));
        ss_rise();
        check("miso_word", mi, exp_tx);
        check("rx_data", rx_data, mo);
        check("rx_valid_pulses", rxv_cnt - rx0, 1);
        check("underrun_pulses", und_cnt - u0, exp_und);
        check("busy_idle", busy, 0);
    endtask

    task automatic b2b(input bit p, input bit h, input bit l, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] mo1, input logic [7:0] mo2);
        logic [7:0] mi1, mi2, e1, e2;
        int exp_und = 0, rx0, u0;
        load_tx(w1);
        rx0 = rxv_cnt; u0 = und_cnt;
        e1 = take_word(exp_und);
        ss_fall(p, h, l);
        xfer(h, l, mo1, 8, 1'b1, 3, w2, mi1);
        check("b2b_rx_first", rx_data, mo1);
        e2 = take_word(exp_und);
        xfer(h, l, mo2, 8, 1'b0, -1, 8'h00, mi2);
        if (!h) void'(take_word(exp_und));
        ss_rise();
        check("b2b_miso_first", mi1, e1);
        check("b2b_miso_second", mi2, e2);
        check("b2b_rx_second", rx_data, mo2);
        check("b2b_rx_valid_pulses", rxv_cnt - rx0, 2);
        check("b2b_underrun_pulses", und_cnt - u0, exp_und);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_miso_oe"}, miso_oe, 0);
        check({tag, "_miso"}, miso, 1);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_underrun"}, tx_underrun, 0);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_data"}, rx_data, 0);
    endtask

    initial begin
        logic [7:0] mi;
        int rx0, u0;

        PRESET = 1'b1; spe = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        PRESET = 1'b0;
        repeat (4) @(negedge PCLK);
        check_reset_outputs("post_reset");

        // mode 0, MSB first
        load_tx(8'hA5);
        run_frame(1'b0, 1'b0, 1'b0, 8'h3C);

        // modes 1..3, LSB first
        for (int m = 1; m < 4; m++) begin
            load_tx(8'h81);
            run_frame(m[1], m[0], 1'b1, 8'h0F);
        end

        // write while full is ignored
        load_tx(8'h55);
        load_tx(8'h66);
        run_frame(1'b0, 1'b1, 1'b0, 8'hC3);

        // back-to-back frames
        b2b(1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 8'h96, 8'h69);
        b2b(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'hE1, 8'h1E);

        // underrun: buffer empty at SS fall
        run_frame(1'b1, 1'b1, 1'b0, 8'h5A);

        // abort after 5 bits
        load_tx(8'h3F);
        rx0 = rxv_cnt;
        void'(take_word(u0));
        ss_fall(1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 8'hFF, 5, 1'b1, -1, 8'h00, mi);
        ss_rise();
        check("abort_rx_valid", rxv_cnt - rx0, 0);
        check("abort_busy", busy, 0);
        check("abort_rx_kept", rx_data, 8'h5A);
        load_tx(8'hC7);
        run_frame(1'b0, 1'b0, 1'b0, 8'hB2);

        // reset mid-frame
        load_tx(8'h5A);
        void'(take_word(u0));
        ss_fall(1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 8'hF0, 3, 1'b1, -1, 8'h00, mi);
        rx0 = rxv_cnt; u0 = und_cnt;
        PRESET = 1'b1;
        @(negedge PCLK);
        check_reset_outputs("mid_reset");
        ss_n = 1'b1; sclk = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        hold_full = 1'b0;
        repeat (HALF) @(negedge PCLK);
        check("mid_reset_no_rx_valid", rxv_cnt - rx0, 0);
        check("mid_reset_no_underrun", und_cnt - u0, 0);
        load_tx(8'h24);
        run_frame(1'b0, 1'b0, 1'b0, 8'h7E);

        // randomized frames against the model
        for (int k = 0; k < 8; k++) begin
            logic [7:0] w, mo;
            w  = 8'($urandom);
            mo = 8'($urandom);
            if ($urandom_range(0, 3) != 0) load_tx(w);
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), mo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
